median_filter_unit: RTL and testbench

MEDIAN_FILTER_UNIT -- requirements
Module: median_filter_unit

---
 rtl/median_filter_unit_pkg.sv | 25 ++
 rtl/median_filter_unit_median9.sv | 30 +++
 rtl/median_filter_unit.sv | 181 ++++++++++++++++++
 tb/tb_median_filter_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_filter_unit_pkg.sv
// Shared widths, bus mode codes and FSM state encoding for the median filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package median_filter_unit_pkg;

    localparam int BIT_WIDTH_DEF       = 8;
    localparam int FULL_BIT_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF      = 18;
    localparam int MODE_ADDR_WIDTH_DEF = 2;

    // Bus address bits [19:18] select what the access targets.
    localparam logic [1:0] MODE_PIXEL  = 2'b00;
    localparam logic [1:0] MODE_CTRL   = 2'b01;
    localparam logic [1:0] MODE_WIDTH  = 2'b10;
    localparam logic [1:0] MODE_HEIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/median_filter_unit_median9.sv
// Median of nine unsigned values: odd-even transposition sorting network.
// Latency: purely combinational.
// Backpressure: none.
module median9 #(
    parameter int W = 8
) (
    input  logic [8:0][W-1:0] vals,
    output logic [W-1:0]      med
);

    logic [8:0][W-1:0] s;
    logic [W-1:0]      t;

    // Nine alternating compare-exchange rounds fully sort nine lanes; lane 4 is the median.
    always_comb begin
        s = vals;
        t = '0;
        for (int r = 0; r < 9; r++) begin
            for (int i = r % 2; i < 8; i += 2) begin
                if (s[i] > s[i+1]) begin
                    t      = s[i];
                    s[i]   = s[i+1];
                    s[i+1] = t;
                end
            end
        end
        med = s[4];
    end

endmodule

// File: rtl/median_filter_unit.sv
// 3x3 median filter over a bus-loaded image, borders copied, result in an output RAM.
// Latency: 1-cycle bus reads; a run takes <= 11 cycles per inner pixel, 2 per border pixel.
// Backpressure: none; while a run is busy bus writes are dropped and pixel/status reads return 0.
module median_filter_unit
    import median_filter_unit_pkg::*;
#(
    parameter int BIT_WIDTH       = BIT_WIDTH_DEF,
    parameter int FULL_BIT_WIDTH  = FULL_BIT_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int MODE_ADDR_WIDTH = MODE_ADDR_WIDTH_DEF
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [FULL_BIT_WIDTH-1:0]           dina_i,
    input  logic [MODE_ADDR_WIDTH+ADDR_WIDTH-1:0] addra_i,
    input  logic                                wea_i,
    input  logic                                ena_i,
    output logic [FULL_BIT_WIDTH-1:0]           douta_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2*ADDR_WIDTH-1:0] MAX_PIX = (2*ADDR_WIDTH)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]   ONE     = ADDR_WIDTH'(1);

    state_e                          state, state_nxt;
    logic [ADDR_WIDTH-1:0]           width, height, row, col, pix_idx;
    logic [ADDR_WIDTH-1:0]           nb_addr, row_base, in_addr;
    logic [1:0]                      kc;
    logic [3:0]                      k;
    logic                            done;
    logic [8:0][BIT_WIDTH-1:0]       win;
    logic [BIT_WIDTH-1:0]            in_ram  [DEPTH];
    logic [BIT_WIDTH-1:0]            out_ram [DEPTH];
    logic [BIT_WIDTH-1:0]            in_rdat, med, out_wdat;
    logic [MODE_ADDR_WIDTH-1:0]      mode;
    logic [ADDR_WIDTH-1:0]           offset;
    logic [2*ADDR_WIDTH-1:0]         area;
    logic busy, bus_wr, bus_rd, start, in_we, dims_bad, small_img, is_border, last_pix;
    logic unused_dina;

    assign mode      = addra_i[MODE_ADDR_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign offset    = addra_i[ADDR_WIDTH-1:0];
    assign busy      = (state != IDLE);
    assign bus_wr    = ena_i && wea_i && !busy;
    assign bus_rd    = ena_i && !wea_i;
    assign start     = bus_wr && (mode == MODE_CTRL) && dina_i[0];
    assign area      = (2*ADDR_WIDTH)'(width) * (2*ADDR_WIDTH)'(height);
    assign dims_bad  = (width == '0) || (height == '0) || (area > MAX_PIX);
    assign small_img = (width < ADDR_WIDTH'(3)) || (height < ADDR_WIDTH'(3));
    assign is_border = small_img || (row == '0) || (row == height - ONE)
                       || (col == '0) || (col == width - ONE);
    assign last_pix  = (row == height - ONE) && (col == width - ONE);
    assign unused_dina = ^dina_i[FULL_BIT_WIDTH-1:ADDR_WIDTH];

    // Neighbour k (0..8, row-major) of the current pixel; border pixels only fetch themselves.
    always_comb begin
        row_base = pix_idx;
        kc       = k[1:0];
        if (k < 4'd3) begin
            row_base = pix_idx - width;
        end else if (k < 4'd6) begin
            kc = 2'(k - 4'd3);
        end else begin
            row_base = pix_idx + width;
            kc       = 2'(k - 4'd6);
        end
        nb_addr = is_border ? pix_idx : row_base + ADDR_WIDTH'(kc) - ONE;
    end

    assign in_addr = busy ? nb_addr : offset;
    assign in_we   = bus_wr && (mode == MODE_PIXEL);

    median9 #(.W(BIT_WIDTH)) u_median9 (
        .vals (win),
        .med  (med)
    );

    // Border pixels pass straight through from the RAM read; inner pixels take the median.
    assign out_wdat = is_border ? in_rdat : med;

    // Input image RAM: bus writes while idle, filter reads while busy.
    always_ff @(posedge CLK) begin
        if (in_we) begin
            in_ram[in_addr] <= dina_i[BIT_WIDTH-1:0];
        end
        in_rdat <= in_ram[in_addr];
    end

    // Output image RAM: written only by the filter.
    always_ff @(posedge CLK) begin
        if (state == WRITE) begin
            out_ram[pix_idx] <= out_wdat;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unusable dimensions go straight to DONE without touching RAM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = dims_bad ? DONE : FETCH;
            FETCH:   if (is_border) state_nxt = WRITE;
                     else if (k == 4'd8) state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = last_pix ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers, pixel walk counters and the 3x3 window capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            width   <= '0;
            height  <= '0;
            row     <= '0;
            col     <= '0;
            pix_idx <= '0;
            k       <= '0;
            win     <= '0;
            done    <= 1'b0;
        end else begin
            if (bus_wr && mode == MODE_WIDTH)  width  <= dina_i[ADDR_WIDTH-1:0];
            if (bus_wr && mode == MODE_HEIGHT) height <= dina_i[ADDR_WIDTH-1:0];
            case (state)
                IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        row     <= '0;
                        col     <= '0;
                        pix_idx <= '0;
                        k       <= '0;
                    end
                end
                FETCH: begin
                    k <= k + 4'd1;
                    // RAM data lags its address by one cycle.
                    if (k != 4'd0) win[k - 4'd1] <= in_rdat;
                end
                CALC: win[8] <= in_rdat;
                WRITE: begin
                    k <= '0;
                    if (!last_pix) begin
                        pix_idx <= pix_idx + ONE;
                        if (col == width - ONE) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

    // Registered bus read data; holds between enabled reads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            douta_o <= '0;
        end else if (bus_rd) begin
            case (mode)
                MODE_PIXEL: douta_o <= busy ? '0 : FULL_BIT_WIDTH'(out_ram[offset]);
                MODE_CTRL:  douta_o <= busy ? '0 : FULL_BIT_WIDTH'(done);
                MODE_WIDTH: douta_o <= FULL_BIT_WIDTH'(width);
                default:    douta_o <= FULL_BIT_WIDTH'(height);
            endcase
        end
    end

endmodule

// File: tb/tb_median_filter_unit.sv
// Directed bench: register vector table, image-case table, then reset and size corner cases.
// Latency: bus tasks take one cycle each; reads sampled on the falling edge.
// Backpressure: n/a.
module tb_median_filter_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] dina_i;
    logic [19:0] addra_i;
    logic        wea_i;
    logic        ena_i;
    logic [31:0] douta_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] img [256];

    median_filter_unit dut (
        .CLK     (CLK),
        .RST     (RST),
        .dina_i  (dina_i),
        .addra_i (addra_i),
        .wea_i   (wea_i),
        .ena_i   (ena_i),
        .douta_o (douta_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  mode;
        logic [17:0] off;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int w;
        int h;
        int kind;
    } img_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        n_checks++;
        if (got <= lim) n_pass++;
        else $display("FAIL %s: took %0d cycles, limit %0d", name, got, lim);
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic bus_write(input logic [1:0] mode, input logic [17:0] off, input logic [31:0] d);
        ena_i = 1'b1; wea_i = 1'b1; addra_i = {mode, off}; dina_i = d;
        @(negedge CLK);
        ena_i = 1'b0; wea_i = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] mode, input logic [17:0] off, output logic [31:0] q);
        ena_i = 1'b1; wea_i = 1'b0; addra_i = {mode, off};
        @(negedge CLK);
        q = douta_o;
        ena_i = 1'b0;
    endtask

    function automatic logic [7:0] gen_px(input int kind, input int r, input int c, input int idx);
        logic [31:0] h;
        if (kind == 0) return (r == 2 && c == 2) ? 8'hFF : 8'h10;
        if (kind == 1) return 8'(idx);
        h = 32'(idx) * 32'd2654435761 + 32'd12345;
        h = h ^ (h >> 15);
        if (h[3:0] == 4'd0) return 8'hFF;
        if (h[3:0] == 4'd1) return 8'h00;
        return 8'h60 + {3'b000, h[8:4]};
    endfunction

    function automatic logic [7:0] model_px(input int r, input int c, input int w, input int h);
        logic [7:0] v [9];
        logic [7:0] t;
        int n = 0;
        if (w < 3 || h < 3 || r == 0 || c == 0 || r == h - 1 || c == w - 1) return img[r*w + c];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[n] = img[(r + dr)*w + c + dc];
                n++;
            end
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        return v[4];
    endfunction

    task automatic load_image(input int w, input int h, input int kind);
        bus_write(2'b10, 18'd0, 32'(w));
        bus_write(2'b11, 18'd0, 32'(h));
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                img[r*w + c] = gen_px(kind, r, c, r*w + c);
                bus_write(2'b00, 18'(r*w + c), {24'd0, img[r*w + c]});
            end
    endtask

    task automatic run_filter(input string name, input int w, input int h);
        int t0;
        int bound;
        bit fin;
        logic [31:0] q;
        bound = 12*w*h + 4;
        bus_write(2'b01, 18'd0, 32'd1);
        t0  = cyc;
        fin = 1'b0;
        for (int i = 0; i < bound + 8 && !fin; i++) begin
            bus_read(2'b01, 18'd0, q);
            if (q[0]) fin = 1'b1;
        end
        check({name, "_done"}, {31'd0, fin}, 32'd1);
        // One extra cycle: the status poll sees done on the read after it rises.
        check_le({name, "_cycles"}, cyc - t0, bound + 1);
    endtask

    task automatic check_image(input string name, input int w, input int h);
        logic [31:0] q;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                bus_read(2'b00, 18'(r*w + c), q);
                check($sformatf("%s_px_r%0d_c%0d", name, r, c), q, {24'd0, model_px(r, c, w, h)});
            end
    endtask

    vec_t vecs [11];
    img_t cases [5];

    initial begin
        logic [31:0] q, q1;

        vecs[0]  = '{1'b0, 2'b01, 18'd0, 32'd0,          32'd0};
        vecs[1]  = '{1'b1, 2'b10, 18'd0, 32'd430,        32'd0};
        vecs[2]  = '{1'b0, 2'b10, 18'd0, 32'd0,          32'd430};
        vecs[3]  = '{1'b0, 2'b11, 18'd0, 32'd0,          32'd0};
        vecs[4]  = '{1'b1, 2'b11, 18'd0, 32'd554,        32'd0};
        vecs[5]  = '{1'b0, 2'b11, 18'd0, 32'd0,          32'd554};
        vecs[6]  = '{1'b1, 2'b01, 18'd0, 32'd0,          32'd0};
        vecs[7]  = '{1'b0, 2'b01, 18'd0, 32'd0,          32'd0};
        vecs[8]  = '{1'b1, 2'b10, 18'd0, 32'hFFFF_FFFF,  32'd0};
        vecs[9]  = '{1'b0, 2'b10, 18'd0, 32'd0,          32'h0003_FFFF};
        vecs[10] = '{1'b0, 2'b10, 18'd5, 32'd0,          32'h0003_FFFF};

        cases[0] = '{5, 5, 0};
        cases[1] = '{4, 4, 1};
        cases[2] = '{2, 2, 1};
        cases[3] = '{11, 9, 2};
        cases[4] = '{7, 2, 2};

        RST = 1'b1; ena_i = 1'b0; wea_i = 1'b0; addra_i = '0; dina_i = '0;
        #2 RST = 1'b0;
        #1 check("reset_douta", douta_o, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Register and status vectors.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].mode, vecs[i].off, vecs[i].dat);
            else begin
                bus_read(vecs[i].mode, vecs[i].off, q);
                check($sformatf("vec%0d", i), q, vecs[i].exp);
            end
        end
        @(negedge CLK);
        @(negedge CLK);
        check("douta_hold", douta_o, 32'h0003_FFFF);

        // Image cases.
        for (int n = 0; n < 5; n++) begin
            load_image(cases[n].w, cases[n].h, cases[n].kind);
            run_filter($sformatf("img%0d", n), cases[n].w, cases[n].h);
            check_image($sformatf("img%0d", n), cases[n].w, cases[n].h);
            if (n == 0) begin
                bus_read(2'b00, 18'd12, q);
                check("spike_centre", q, 32'h10);
            end
            if (n == 1) begin
                bus_read(2'b00, 18'd5, q);
                check("ramp_inner_1_1", q, 32'd5);
                bus_read(2'b00, 18'd10, q);
                check("ramp_inner_2_2", q, 32'd10);
            end
        end

        // Oversized image: done one cycle after start, output RAM untouched.
        bus_write(2'b10, 18'd0, 32'd430);
        bus_write(2'b11, 18'd0, 32'd700);
        bus_write(2'b01, 18'd0, 32'd1);
        bus_read(2'b01, 18'd0, q1);
        bus_read(2'b01, 18'd0, q);
        check("oversize_done", q, 32'd1);
        bus_read(2'b00, 18'd0, q);
        check("oversize_ram_kept", q, {24'd0, img[0]});

        // Zero width also completes at once.
        bus_write(2'b10, 18'd0, 32'd0);
        bus_write(2'b01, 18'd0, 32'd1);
        bus_read(2'b01, 18'd0, q1);
        bus_read(2'b01, 18'd0, q);
        check("zero_width_done", q, 32'd1);

        // Reset in the middle of a run, then a clean rerun.
        load_image(11, 9, 2);
        bus_write(2'b01, 18'd0, 32'd1);
        repeat (60) @(negedge CLK);
        bus_read(2'b01, 18'd0, q);
        check("midrun_busy_status", q, 32'd0);
        RST = 1'b0;
        #1 check("midrun_reset_douta", douta_o, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        bus_read(2'b01, 18'd0, q);
        check("post_reset_status", q, 32'd0);
        bus_read(2'b10, 18'd0, q);
        check("post_reset_width", q, 32'd0);
        bus_write(2'b10, 18'd0, 32'd11);
        bus_read(2'b10, 18'd0, q);
        check("post_reset_idle_write", q, 32'd11);
        bus_write(2'b11, 18'd0, 32'd9);
        run_filter("rerun", 11, 9);
        check_image("rerun", 11, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
